// File: rtl/add_sub_sequencer_if.sv
// Control bus between the add/subtract sequencer and the datapath blocks.
// The slave modport is the sequencer's view. The master modport is the
// datapath's view: it supplies run, opcode and carry, and receives the
// strobes.
interface add_sub_sequencer_if #(
  parameter int OP_W = 4
);
  logic            run;
  logic [OP_W-1:0] ir_opcode;
  logic            c_in;

  logic            pc_oe;
  logic            pc_inc;
  logic            pc_ld;
  logic            mar_ld;
  logic            ram_oe;
  logic            ir_ld;
  logic            ir_oe;
  logic            a_ld;
  logic            a_oe;
  logic            b_ld;
  logic            out_ld;
  logic            alu_sub;
  logic            alu_oe;
  logic            halted;
  logic [2:0]      state;
  logic            cf;

  modport slave (
    input  run, ir_opcode, c_in,
    output pc_oe, pc_inc, pc_ld, mar_ld, ram_oe, ir_ld, ir_oe,
           a_ld, a_oe, b_ld, out_ld, alu_sub, alu_oe, halted, state, cf
  );

  modport master (
    output run, ir_opcode, c_in,
    input  pc_oe, pc_inc, pc_ld, mar_ld, ram_oe, ir_ld, ir_oe,
           a_ld, a_oe, b_ld, out_ld, alu_sub, alu_oe, halted, state, cf
  );
endinterface

// File: rtl/add_sub_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator computer.
// Each instruction walks a six-T-state ring. HLT parks the machine until
// reset. Defining CARRY_JUMP_EN adds the carry flag and the JMP/JC jumps.
// Without the macro, CF and PC_LD are tied low and 0x6/0x7 decode as NOP.
module add_sub_sequencer #(
  parameter int T_STATES = 6,
  parameter int OP_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  add_sub_sequencer_if.slave  bus
);

  if (T_STATES != 6) begin : gBadTStates
    $error("add_sub_sequencer: T_STATES must be 6");
  end
  if (OP_W != 4) begin : gBadOpW
    $error("add_sub_sequencer: OP_W must be 4");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    T6   = 3'd6,
    HALT = 3'd7
  } state_e;

  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  state_e state_q, state_d;
  logic   cfFlag;

`ifdef CARRY_JUMP_EN
  localparam logic [OP_W-1:0] OP_JMP = 4'h6;
  localparam logic [OP_W-1:0] OP_JC  = 4'h7;

  logic cf_q, cf_d;

  // Capture the adder carry at the edge that closes T6 of ADD/SUB; hold otherwise
  always_comb begin
    cf_d = cf_q;
    if (state_q == T6 && (bus.ir_opcode == OP_ADD || bus.ir_opcode == OP_SUB)) begin
      cf_d = bus.c_in;
    end
  end

  // Carry flag register, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cf_q <= 1'b0;
    end else begin
      cf_q <= cf_d;
    end
  end

  assign cfFlag = cf_q;
`else
  logic unusedCin;
  assign unusedCin = bus.c_in;
  assign cfFlag    = 1'b0;
`endif

  // T-state register; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next T-state and the combinational decode of every control strobe
  always_comb begin
    state_d     = state_q;
    bus.pc_oe   = 1'b0;
    bus.pc_inc  = 1'b0;
    bus.pc_ld   = 1'b0;
    bus.mar_ld  = 1'b0;
    bus.ram_oe  = 1'b0;
    bus.ir_ld   = 1'b0;
    bus.ir_oe   = 1'b0;
    bus.a_ld    = 1'b0;
    bus.a_oe    = 1'b0;
    bus.b_ld    = 1'b0;
    bus.out_ld  = 1'b0;
    bus.alu_sub = 1'b0;
    bus.alu_oe  = 1'b0;
    bus.halted  = 1'b0;
    bus.state   = state_q;
    bus.cf      = cfFlag;

    case (state_q)
      IDLE: begin
        if (bus.run) state_d = T1;
      end
      T1: begin
        bus.pc_oe  = 1'b1;
        bus.mar_ld = 1'b1;
        state_d    = T2;
      end
      T2: begin
        bus.pc_inc = 1'b1;
        state_d    = T3;
      end
      T3: begin
        bus.ram_oe = 1'b1;
        bus.ir_ld  = 1'b1;
        state_d    = T4;
      end
      T4: begin
        state_d = (bus.ir_opcode == OP_HLT) ? HALT : T5;
        case (bus.ir_opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            bus.ir_oe  = 1'b1;
            bus.mar_ld = 1'b1;
          end
          OP_OUT: begin
            bus.a_oe   = 1'b1;
            bus.out_ld = 1'b1;
          end
`ifdef CARRY_JUMP_EN
          OP_JMP: begin
            bus.ir_oe = 1'b1;
            bus.pc_ld = 1'b1;
          end
          OP_JC: begin
            bus.ir_oe = cf_q;
            bus.pc_ld = cf_q;
          end
`endif
          default: ;
        endcase
      end
      T5: begin
        state_d = T6;
        case (bus.ir_opcode)
          OP_LDA: begin
            bus.ram_oe = 1'b1;
            bus.a_ld   = 1'b1;
          end
          OP_ADD: begin
            bus.ram_oe = 1'b1;
            bus.b_ld   = 1'b1;
          end
          OP_SUB: begin
            bus.ram_oe  = 1'b1;
            bus.b_ld    = 1'b1;
            bus.alu_sub = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        state_d = bus.run ? T1 : IDLE;
        case (bus.ir_opcode)
          OP_ADD: begin
            bus.alu_oe = 1'b1;
            bus.a_ld   = 1'b1;
          end
          OP_SUB: begin
            bus.alu_oe  = 1'b1;
            bus.a_ld    = 1'b1;
            bus.alu_sub = 1'b1;
          end
          default: ;
        endcase
      end
      HALT: begin
        bus.halted = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_add_sub_sequencer.sv
// Self-checking bench for add_sub_sequencer. A phase/opcode-level model
// predicts STATE, the control strobes and CF, and is compared every cycle.
// Directed literal sequences pin both the DUT and the model. When
// CARRY_JUMP_EN is defined, the carry/jump expectations follow that build.
module tb_add_sub_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  add_sub_sequencer_if bus ();

  add_sub_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef CARRY_JUMP_EN
  localparam bit kCarry = 1'b1;
`else
  localparam bit kCarry = 1'b0;
`endif

  localparam logic [13:0] kPcOe   = 14'h2000;
  localparam logic [13:0] kPcInc  = 14'h1000;
  localparam logic [13:0] kPcLd   = 14'h0800;
  localparam logic [13:0] kMarLd  = 14'h0400;
  localparam logic [13:0] kRamOe  = 14'h0200;
  localparam logic [13:0] kIrLd   = 14'h0100;
  localparam logic [13:0] kIrOe   = 14'h0080;
  localparam logic [13:0] kALd    = 14'h0040;
  localparam logic [13:0] kAOe    = 14'h0020;
  localparam logic [13:0] kBLd    = 14'h0010;
  localparam logic [13:0] kOutLd  = 14'h0008;
  localparam logic [13:0] kAluSub = 14'h0004;
  localparam logic [13:0] kAluOe  = 14'h0002;
  localparam logic [13:0] kHalted = 14'h0001;

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 1'b0;
  int mPhase     = 0;
  bit mCf        = 1'b0;
  int haltCount  = 0;

  logic [13:0] dutCtrl;
  assign dutCtrl = {bus.pc_oe, bus.pc_inc, bus.pc_ld, bus.mar_ld, bus.ram_oe,
                    bus.ir_ld, bus.ir_oe, bus.a_ld, bus.a_oe, bus.b_ld,
                    bus.out_ld, bus.alu_sub, bus.alu_oe, bus.halted};

  // Control strobes required for a given phase (0 idle, 1..6 T-states, 7 halt)
  function automatic logic [13:0] expCtrl(int phase, logic [3:0] op, bit cf);
    logic [13:0] c;
    int k;
    c = '0;
    k = phase - 4;
    if (phase == 1) c = kPcOe | kMarLd;
    else if (phase == 2) c = kPcInc;
    else if (phase == 3) c = kRamOe | kIrLd;
    else if (phase == 7) c = kHalted;
    else if (phase >= 4 && phase <= 6) begin
      case (op)
        4'h0: c = (k == 0) ? (kIrOe | kMarLd) : (k == 1) ? (kRamOe | kALd) : '0;
        4'h1, 4'h2: begin
          c = (k == 0) ? (kIrOe | kMarLd) : (k == 1) ? (kRamOe | kBLd) : (kAluOe | kALd);
          if (op == 4'h2 && k > 0) c = c | kAluSub;
        end
        4'hE: if (k == 0) c = kAOe | kOutLd;
        4'h6: if (kCarry && k == 0) c = kIrOe | kPcLd;
        4'h7: if (kCarry && k == 0 && cf) c = kIrOe | kPcLd;
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  // Behavioural model: phase advance and carry capture
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase = 0;
      mCf    = 1'b0;
    end else begin
      if (mPhase == 0) mPhase = bus.run ? 1 : 0;
      else if (mPhase == 7) mPhase = 7;
      else if (mPhase == 4) mPhase = (bus.ir_opcode == 4'hF) ? 7 : 5;
      else if (mPhase == 6) begin
        if (kCarry && (bus.ir_opcode == 4'h1 || bus.ir_opcode == 4'h2)) mCf = bus.c_in;
        mPhase = bus.run ? 1 : 0;
      end else mPhase = mPhase + 1;
    end
  end

  task automatic compareValue(string name, logic [31:0] actual, logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (checkEn) begin
      compareValue("model state", 32'(bus.state), 32'(mPhase));
      compareValue("model ctrl", 32'(dutCtrl), 32'(expCtrl(mPhase, bus.ir_opcode, mCf)));
      compareValue("model cf", 32'(bus.cf), 32'(mCf));
      compareValue("single bus driver",
                   32'((32'(bus.pc_oe) + 32'(bus.ram_oe) + 32'(bus.ir_oe) +
                        32'(bus.a_oe) + 32'(bus.alu_oe)) <= 1), 32'd1);
    end
  end

  task automatic applyStimulus(bit runV, logic [3:0] op, bit cin);
    @(posedge clk);
    #2;
    bus.run       = runV;
    bus.ir_opcode = op;
    bus.c_in      = cin;
  endtask

  task automatic checkOutput(string name, int expState, logic [13:0] expC, bit expCf);
    @(negedge clk);
    compareValue({name, " state"}, 32'(bus.state), 32'(expState));
    compareValue({name, " ctrl"}, 32'(dutCtrl), 32'(expC));
    compareValue({name, " cf"}, 32'(bus.cf), 32'(expCf));
    compareValue({name, " model pin"}, 32'(mPhase), 32'(expState));
  endtask

  function automatic logic [3:0] pickOp();
    int r;
    r = $urandom_range(0, 19);
    if (r <= 3) return 4'h0;
    if (r <= 7) return 4'h1;
    if (r <= 11) return 4'h2;
    if (r <= 13) return 4'hE;
    if (r <= 15) return 4'h6;
    if (r <= 17) return 4'h7;
    if (r == 18) return 4'hF;
    return 4'($urandom_range(0, 15));
  endfunction

  // Bounded run time
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequences followed by randomized traffic
  initial begin
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.ir_opcode = 4'h0;
    bus.c_in      = 1'b0;
    checkOutput("reset", 0, '0, 1'b0);
    #2;
    rst_n   = 1'b1;
    bus.run = 1'b1;
    checkEn = 1'b1;

    checkOutput("lda T1", 1, kPcOe | kMarLd, 1'b0);
    checkOutput("lda T2", 2, kPcInc, 1'b0);
    checkOutput("lda T3", 3, kRamOe | kIrLd, 1'b0);
    checkOutput("lda T4", 4, kIrOe | kMarLd, 1'b0);
    checkOutput("lda T5", 5, kRamOe | kALd, 1'b0);
    checkOutput("lda T6", 6, '0, 1'b0);
    checkOutput("lda next T1", 1, kPcOe | kMarLd, 1'b0);

    applyStimulus(1'b1, 4'h2, 1'b0);
    checkOutput("sub T2", 2, kPcInc, 1'b0);
    checkOutput("sub T3", 3, kRamOe | kIrLd, 1'b0);
    checkOutput("sub T4", 4, kIrOe | kMarLd, 1'b0);
    checkOutput("sub T5", 5, kRamOe | kBLd | kAluSub, 1'b0);
    checkOutput("sub T6", 6, kAluOe | kALd | kAluSub, 1'b0);
    checkOutput("sub next T1", 1, kPcOe | kMarLd, 1'b0);

    applyStimulus(1'b1, 4'h1, 1'b1);
    checkOutput("add T2", 2, kPcInc, 1'b0);
    checkOutput("add T3", 3, kRamOe | kIrLd, 1'b0);
    checkOutput("add T4", 4, kIrOe | kMarLd, 1'b0);
    checkOutput("add T5", 5, kRamOe | kBLd, 1'b0);
    checkOutput("add T6", 6, kAluOe | kALd, 1'b0);
    checkOutput("add carry T1", 1, kPcOe | kMarLd, kCarry);

    applyStimulus(1'b1, 4'h7, 1'b0);
    checkOutput("jc taken T2", 2, kPcInc, kCarry);
    checkOutput("jc taken T3", 3, kRamOe | kIrLd, kCarry);
    checkOutput("jc taken T4", 4, kCarry ? (kIrOe | kPcLd) : 14'h0, kCarry);
    checkOutput("jc taken T5", 5, '0, kCarry);
    checkOutput("jc taken T6", 6, '0, kCarry);
    checkOutput("jc taken T1", 1, kPcOe | kMarLd, kCarry);

    applyStimulus(1'b1, 4'h2, 1'b0);
    checkOutput("sub2 T2", 2, kPcInc, kCarry);
    checkOutput("sub2 T3", 3, kRamOe | kIrLd, kCarry);
    checkOutput("sub2 T4", 4, kIrOe | kMarLd, kCarry);
    checkOutput("sub2 T5", 5, kRamOe | kBLd | kAluSub, kCarry);
    checkOutput("sub2 T6", 6, kAluOe | kALd | kAluSub, kCarry);
    checkOutput("sub2 clear T1", 1, kPcOe | kMarLd, 1'b0);

    applyStimulus(1'b1, 4'h7, 1'b0);
    checkOutput("jc not T2", 2, kPcInc, 1'b0);
    checkOutput("jc not T3", 3, kRamOe | kIrLd, 1'b0);
    checkOutput("jc not T4", 4, '0, 1'b0);
    checkOutput("jc not T5", 5, '0, 1'b0);
    checkOutput("jc not T6", 6, '0, 1'b0);
    checkOutput("jc not T1", 1, kPcOe | kMarLd, 1'b0);

    applyStimulus(1'b1, 4'h0, 1'b0);
    checkOutput("rundrop T2", 2, kPcInc, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("rundrop T3", 3, kRamOe | kIrLd, 1'b0);
    checkOutput("rundrop T4", 4, kIrOe | kMarLd, 1'b0);
    checkOutput("rundrop T5", 5, kRamOe | kALd, 1'b0);
    checkOutput("rundrop T6", 6, '0, 1'b0);
    checkOutput("rundrop idle", 0, '0, 1'b0);
    applyStimulus(1'b1, 4'h0, 1'b0);
    checkOutput("rundrop idle hold", 0, '0, 1'b0);
    checkOutput("rundrop restart", 1, kPcOe | kMarLd, 1'b0);

    checkOutput("async T2", 2, kPcInc, 1'b0);
    checkOutput("async T3", 3, kRamOe | kIrLd, 1'b0);
    checkOutput("async T4", 4, kIrOe | kMarLd, 1'b0);
    checkOutput("async T5", 5, kRamOe | kALd, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    compareValue("async reset state", 32'(bus.state), 32'd0);
    compareValue("async reset ctrl", 32'(dutCtrl), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    checkOutput("post reset idle", 0, '0, 1'b0);
    checkOutput("post reset T1", 1, kPcOe | kMarLd, 1'b0);

    applyStimulus(1'b1, 4'hF, 1'b0);
    checkOutput("hlt T2", 2, kPcInc, 1'b0);
    checkOutput("hlt T3", 3, kRamOe | kIrLd, 1'b0);
    checkOutput("hlt T4", 4, '0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'(i % 2), 4'hF, 1'(i % 3 == 0));
      checkOutput("halt hold", 7, kHalted, 1'b0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    compareValue("halt reset state", 32'(bus.state), 32'd0);
    compareValue("halt reset halted", 32'(bus.halted), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 59) == 0 || haltCount > 6) begin
        rst_n     = 1'b0;
        haltCount = 0;
      end
      bus.run  = ($urandom_range(0, 9) != 0);
      bus.c_in = 1'($urandom_range(0, 1));
      if (mPhase <= 3) bus.ir_opcode = pickOp();
      haltCount = (mPhase == 7) ? haltCount + 1 : 0;
    end
    @(negedge clk);
    checkEn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/add_sub_sequencer.md
Name: add_sub_sequencer

Overview:
- Fetch/decode/execute control sequencer for the 8-bit accumulator computer; drives the add/subtract unit (SUB, OE), A and B registers, PC, MAR, RAM, IR and output register.
- Six-T-state ring per instruction; opcode taken from IR upper nibble. HLT freezes the machine until reset.
- Sits between the IR/ALU datapath and the bus-driving blocks; it is the only source of bus load and output-enable strobes.

Parameters:
- T_STATES, 6, T-states per instruction; fixed at 6, and any other value is a synthesis error.
- OP_W, 4, opcode width; fixed at 4.

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- RST_N  input  1  asynchronous active-low reset
- RUN  input  1  run enable; sampled only on entry to T1
- IR_OPCODE  input  4  IR[7:4]
- C_IN  input  1  carry from add/subtract unit (c_out)
- PC_OE, PC_INC, PC_LD  output  1 each  program counter controls
- MAR_LD, RAM_OE, IR_LD, IR_OE  output  1 each  memory/IR controls
- A_LD, A_OE, B_LD, OUT_LD  output  1 each  register controls
- ALU_SUB, ALU_OE  output  1 each  to the add/subtract unit's SUB and OE inputs
- HALTED  output  1  high in HALT state
- STATE  output  3  IDLE=0, T1..T6=1..6, HALT=7
- CF  output  1  carry flag (see Optional Feature)

Behaviour:
- State register only; all control outputs are a combinational decode of STATE and IR_OPCODE, with no other input paths. Controls change only after rising CLK or after RST_N falls.
- Reset (async, any time, including mid-instruction): STATE=IDLE, CF=0; all control outputs 0, HALTED=0. An interrupted instruction is abandoned with no partial completion.
- IDLE: controls 0. If RUN=1 at a rising edge, go to T1; otherwise stay in IDLE.
- T1->T2->T3->T4->T5->T6 each take one cycle. At T6, go to T1 if RUN=1, else go to IDLE. Deasserting RUN mid-instruction does not stop the instruction.
- Fetch, all opcodes:
  - T1: PC_OE, MAR_LD.
  - T2: PC_INC.
  - T3: RAM_OE, IR_LD.
  - IR_OPCODE is valid from T4 onward.
- LDA (0x0): T4 IR_OE+MAR_LD; T5 RAM_OE+A_LD; T6 none.
- ADD (0x1): T4 IR_OE+MAR_LD; T5 RAM_OE+B_LD; T6 ALU_OE+A_LD, ALU_SUB=0.
- SUB (0x2): same as ADD. ALU_SUB=1 in T5 and T6 so SUB is stable one cycle before and throughout ALU_OE.
- OUT (0xE): T4 A_OE+OUT_LD; T5, T6 none.
- HLT (0xF): at T4 go to HALT (7). All controls 0, HALTED=1. Only RST_N leaves HALT; RUN is ignored.
- Other opcodes: NOP; T4-T6 with no controls asserted.
- Never asserted together: two bus drivers (PC_OE, RAM_OE, IR_OE, A_OE, ALU_OE). The bench checks this every cycle.
- PC_LD=0 unless the optional feature is enabled.

Optional Feature:
- Macro CARRY_JUMP_EN.
- Defined:
  - CF is a flop. At the rising edge ending T6 of ADD/SUB, CF<=C_IN; CF holds otherwise; reset clears it.
  - JMP (0x6): T4 IR_OE+PC_LD.
  - JC (0x7): T4 IR_OE+PC_LD only if CF=1, else no controls.
  - T5 and T6 of JMP/JC: no controls.
- Undefined:
  - No CF flop; CF tied 0, PC_LD tied 0.
  - 0x6 and 0x7 decode as NOP.

Test Plan:
- Reset then RUN=1, IR_OPCODE=0x0 (LDA) -> STATE 0,1,2,3,4,5,6,1. Controls: T1 PC_OE+MAR_LD, T2 PC_INC, T3 RAM_OE+IR_LD, T4 IR_OE+MAR_LD, T5 RAM_OE+A_LD, T6 none.
- IR_OPCODE=0x2 (SUB) -> ALU_SUB=1 in T5 and T6; ALU_OE+A_LD only in T6; ALU_SUB=0 in T1-T4. Repeat with 0x1 -> ALU_SUB=0 in all states.
- IR_OPCODE=0xF at T4 -> STATE=7, HALTED=1, all controls 0 for 20 cycles with RUN toggling. RST_N low -> STATE=0, HALTED=0.
- RUN dropped during T3 -> instruction completes through T6, then STATE=0. RUN=1 again -> T1 on next edge.
- RST_N asserted asynchronously mid-T5 (between edges) -> controls 0 and STATE=0 immediately, before the next CLK edge.
- CARRY_JUMP_EN: ADD with C_IN=1 at T6 -> CF=1. JC -> PC_LD=1 in T4. SUB with C_IN=0 -> CF=0. JC -> PC_LD=0. Without the macro, 0x7 -> PC_LD=0 and CF=0 throughout.
